// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through word cache.
package dm_cache_pkg;

  localparam int unsigned LINES_DEF     = 64;
  localparam int unsigned MEM_WORDS_DEF = 32768;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_WRITE  = 3'd2,
    S_BYPASS = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  function automatic int unsigned idx_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned lines);
    return 32 - 2 - $clog2(lines);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// picorv32-style native memory bus; used for both the CPU side and the memory side.
interface dm_cache_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
  modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/dm_cache_array.sv
// Tag/valid/data storage: combinational lookup, byte-masked synchronous write,
// valid bits cleared asynchronously by reset and synchronously by clr_i.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter  int unsigned LINES = LINES_DEF,
  localparam int unsigned IDX   = idx_width(LINES),
  localparam int unsigned TAG_W = tag_width(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [IDX-1:0]   rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic             wr_fill_i,
  input  logic [IDX-1:0]   wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i,
  input  logic [3:0]       wr_mask_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // A clear wins over a fill landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_fill_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= merge_bytes(data_q[wr_idx_i], wr_data_i, wr_mask_i);
      if (wr_fill_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache for the picorv32 bus.
// Optional read hit/miss counters are built when CACHE_STATS_EN is defined.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int unsigned LINES     = LINES_DEF,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  dm_cache_if.slave   cpu,
  dm_cache_if.master  mem,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX   = idx_width(LINES);
  localparam int unsigned TAG_W = tag_width(LINES);

  state_e           state_q;
  logic [IDX-1:0]   req_idx_q;
  logic [TAG_W-1:0] req_tag_q;
  logic             m_valid_q;
  logic [31:0]      m_addr_q;
  logic [31:0]      m_wdata_q;
  logic [3:0]       m_wstrb_q;
  logic             mem_ready_q;
  logic [31:0]      mem_rdata_q;
  logic             flush_pend_q;

  logic [IDX-1:0]   cpu_idx_s;
  logic [TAG_W-1:0] cpu_tag_s;
  logic [IDX-1:0]   lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_valid_s;
  logic [TAG_W-1:0] lk_rtag_s;
  logic [31:0]      lk_data_s;
  logic             hit_s;
  logic             is_write_s;
  logic             cacheable_s;
  logic             clear_s;
  logic             accept_s;
  logic             read_hit_s;
  logic             read_miss_s;
  logic             m_done_s;
  logic             wr_en_s;
  logic             wr_fill_s;
  logic [31:0]      wr_data_s;
  logic [3:0]       wr_mask_s;
  logic             unused_addr_lsb_s;

  assign cpu_idx_s         = cpu.addr[IDX+1:2];
  assign cpu_tag_s         = cpu.addr[31:IDX+2];
  assign unused_addr_lsb_s = ^cpu.addr[1:0];

  // In IDLE the lookup serves the incoming request, otherwise the captured one.
  always_comb begin
    lk_idx_s = req_idx_q;
    lk_tag_s = req_tag_q;
    if (state_q == S_IDLE) begin
      lk_idx_s = cpu_idx_s;
      lk_tag_s = cpu_tag_s;
    end else begin
      lk_idx_s = req_idx_q;
      lk_tag_s = req_tag_q;
    end
  end

  assign hit_s       = lk_valid_s && (lk_rtag_s == lk_tag_s);
  assign is_write_s  = (cpu.wstrb != 4'b0000);
  assign cacheable_s = ({2'b00, cpu.addr[31:2]} < 32'(MEM_WORDS));
  assign clear_s     = (state_q == S_IDLE) && (flush || flush_pend_q);
  assign accept_s    = (state_q == S_IDLE) && !clear_s && cpu.valid && !mem_ready_q;
  assign read_hit_s  = accept_s && !is_write_s && cacheable_s && hit_s;
  assign read_miss_s = accept_s && !is_write_s && cacheable_s && !hit_s;
  assign m_done_s    = m_valid_q && mem.ready;

  // Fills write the whole line; write hits merge only the strobed bytes.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_fill_s = 1'b0;
    wr_data_s = m_wdata_q;
    wr_mask_s = m_wstrb_q;
    if (m_done_s && (state_q == S_FILL)) begin
      wr_en_s   = 1'b1;
      wr_fill_s = 1'b1;
      wr_data_s = mem.rdata;
      wr_mask_s = 4'b1111;
    end else if (m_done_s && (state_q == S_WRITE) && hit_s) begin
      wr_en_s   = 1'b1;
      wr_fill_s = 1'b0;
      wr_data_s = m_wdata_q;
      wr_mask_s = m_wstrb_q;
    end else begin
      wr_en_s   = 1'b0;
      wr_fill_s = 1'b0;
    end
  end

  dm_cache_array #(.LINES(LINES)) u_array (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (clear_s),
    .rd_idx_i   (lk_idx_s),
    .rd_valid_o (lk_valid_s),
    .rd_tag_o   (lk_rtag_s),
    .rd_data_o  (lk_data_s),
    .wr_en_i    (wr_en_s),
    .wr_fill_i  (wr_fill_s),
    .wr_idx_i   (req_idx_q),
    .wr_tag_i   (req_tag_q),
    .wr_data_i  (wr_data_s),
    .wr_mask_i  (wr_mask_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_idx_q    <= '0;
      req_tag_q    <= '0;
      m_valid_q    <= 1'b0;
      m_addr_q     <= 32'h0000_0000;
      m_wdata_q    <= 32'h0000_0000;
      m_wstrb_q    <= 4'b0000;
      mem_ready_q  <= 1'b0;
      mem_rdata_q  <= 32'h0000_0000;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear_s) begin
            flush_pend_q <= 1'b0;
          end else if (accept_s) begin
            req_idx_q <= cpu_idx_s;
            req_tag_q <= cpu_tag_s;
            if (read_hit_s) begin
              mem_rdata_q <= lk_data_s;
              mem_ready_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              m_valid_q <= 1'b1;
              m_addr_q  <= {cpu.addr[31:2], 2'b00};
              m_wdata_q <= cpu.wdata;
              m_wstrb_q <= cpu.wstrb;
              state_q   <= is_write_s ? S_WRITE : (cacheable_s ? S_FILL : S_BYPASS);
            end
          end
        end
        S_FILL, S_WRITE, S_BYPASS: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (m_done_s) begin
            m_valid_q   <= 1'b0;
            mem_ready_q <= 1'b1;
            if (state_q != S_WRITE) begin
              mem_rdata_q <= mem.rdata;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          mem_ready_q <= 1'b0;
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          m_valid_q   <= 1'b0;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.ready = mem_ready_q;
  assign cpu.rdata = mem_rdata_q;
  assign mem.valid = m_valid_q;
  assign mem.addr  = m_addr_q;
  assign mem.wdata = m_wdata_q;
  assign mem.wstrb = m_wstrb_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
    end else begin
      if (read_hit_s) begin
        hit_cnt_q <= hit_cnt_q + 32'h0000_0001;
      end
      if (read_miss_s) begin
        miss_cnt_q <= miss_cnt_q + 32'h0000_0001;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = read_miss_s;
  assign hit_count      = 32'h0000_0000;
  assign miss_count     = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed scenarios plus randomized traffic
// checked against a line-presence model and a golden memory image.
module tb_dm_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dm_cache_if cbus();
  dm_cache_if mbus();

  dm_cache dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .cpu        (cbus),
    .mem        (mbus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_delay = 11;
  int wr_delay = 16;
  int tx_count = 0;
  int last_ready_cyc = 0;
  int ready_seen_cyc = 0;
  logic [31:0] last_m_addr, last_m_wdata;
  logic [3:0]  last_m_wstrb;
  bit hold_err = 0;

  logic [31:0] mem_img [int unsigned];
  logic [31:0] gold    [int unsigned];

  bit          pres_v [64];
  int unsigned pres_w [64];
  int          hits_exp, miss_exp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] wmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned w);
    if (mem_img.exists(w)) return mem_img[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] gold_rd(input int unsigned w);
    if (gold.exists(w)) return gold[w];
    return init_word(w);
  endfunction

  // Reference model: which word each line holds; returns 1 when a read should hit.
  function automatic bit mdl_read(input int unsigned w);
    int unsigned idx;
    idx = w % 64;
    if (w >= 32768) return 1'b0;
    if (pres_v[idx] && pres_w[idx] == w) begin
      hits_exp++;
      return 1'b1;
    end
    pres_v[idx] = 1'b1;
    pres_w[idx] = w;
    miss_exp++;
    return 1'b0;
  endfunction

  function automatic void mdl_write(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
    gold[w] = wmerge(gold_rd(w), d, s);
  endfunction

  function automatic void mdl_flush();
    for (int i = 0; i < 64; i++) pres_v[i] = 1'b0;
  endfunction

  function automatic void mdl_reset();
    mdl_flush();
    hits_exp = 0;
    miss_exp = 0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef CACHE_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0000_0000;
`endif
  endfunction

  // Slow memory: m_ready after rd_delay/wr_delay cycles of m_valid.
  initial begin
    int wcnt;
    bit acked;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    int unsigned w;
    wcnt = 0; acked = 0; a0 = 0; d0 = 0; s0 = 0;
    mbus.ready = 1'b0;
    mbus.rdata = 32'h0;
    forever begin
      @(negedge clk);
      mbus.ready = 1'b0;
      if (mbus.valid !== 1'b1) begin
        wcnt = 0;
        acked = 0;
      end else if (!acked) begin
        if (wcnt == 0) begin
          a0 = mbus.addr; d0 = mbus.wdata; s0 = mbus.wstrb;
        end else if (mbus.addr !== a0 || mbus.wdata !== d0 || mbus.wstrb !== s0) begin
          hold_err = 1'b1;
        end
        wcnt++;
        if (wcnt >= ((s0 != 4'b0000) ? wr_delay : rd_delay)) begin
          w = 32'(a0[31:2]);
          if (s0 == 4'b0000) mbus.rdata = mem_rd(w);
          else mem_img[w] = wmerge(mem_rd(w), d0, s0);
          mbus.ready = 1'b1;
          acked = 1'b1;
          tx_count++;
          last_ready_cyc = cyc;
          last_m_addr = a0; last_m_wdata = d0; last_m_wstrb = s0;
        end
      end
    end
  end

  task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            input int flush_at, input int reset_at,
                            output logic [31:0] rdata, output int lat, output int ntx, output bit done);
    int k;
    int start_tx;
    @(negedge clk);
    start_tx = tx_count;
    done = 1'b0; lat = 0; rdata = 32'h0;
    cbus.valid = 1'b1; cbus.addr = addr; cbus.wdata = wdata; cbus.wstrb = wstrb;
    if (flush_at == 0) flush = 1'b1;
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
      flush = 1'b0;
      if (cbus.ready === 1'b1) begin
        done = 1'b1; rdata = cbus.rdata; lat = k; ready_seen_cyc = cyc;
      end else if (k == flush_at) begin
        flush = 1'b1;
      end else if (k == reset_at) begin
        reset = 1'b1;
        k = 400;
      end
    end
    cbus.valid = 1'b0;
    cbus.wstrb = 4'b0000;
    ntx = tx_count - start_tx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (cbus.ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready got %b want 0", cbus.ready); end
    n_vec++; if (cbus.rdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_rdata got %h want 0", cbus.rdata); end
    n_vec++; if (mbus.valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got %b want 0", mbus.valid); end
    n_vec++; if (mbus.addr !== 32'h0) begin n_err++; $display("FAIL rst_m_addr got %h want 0", mbus.addr); end
    n_vec++; if (mbus.wdata !== 32'h0) begin n_err++; $display("FAIL rst_m_wdata got %h want 0", mbus.wdata); end
    n_vec++; if (mbus.wstrb !== 4'h0) begin n_err++; $display("FAIL rst_m_wstrb got %h want 0", mbus.wstrb); end
    n_vec++; if (hit_count !== 32'h0) begin n_err++; $display("FAIL rst_hits got %0d want 0", hit_count); end
    n_vec++; if (miss_count !== 32'h0) begin n_err++; $display("FAIL rst_misses got %0d want 0", miss_count); end
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; int lat, ntx; bit done, h;
    cpu_access(32'h100, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h40);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL cold_timeout got %b want 1", done); end
    n_vec++; if (ntx !== 1 || h) begin n_err++; $display("FAIL cold_mtx got %0d want 1", ntx); end
    n_vec++; if (last_m_addr !== 32'h100) begin n_err++; $display("FAIL cold_m_addr got %h want 100", last_m_addr); end
    n_vec++; if (ready_seen_cyc !== last_ready_cyc + 1) begin n_err++; $display("FAIL cold_resp_lag got %0d want %0d", ready_seen_cyc, last_ready_cyc + 1); end
    n_vec++; if (lat !== rd_delay + 1) begin n_err++; $display("FAIL cold_lat got %0d want %0d", lat, rd_delay + 1); end
    n_vec++; if (rd !== gold_rd(32'h40)) begin n_err++; $display("FAIL cold_data got %h want %h", rd, gold_rd(32'h40)); end
    cpu_access(32'h100, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h40);
    n_vec++; if (lat !== 1 || !h) begin n_err++; $display("FAIL hit_lat got %0d want 1", lat); end
    n_vec++; if (ntx !== 0) begin n_err++; $display("FAIL hit_mtx got %0d want 0", ntx); end
    n_vec++; if (rd !== gold_rd(32'h40)) begin n_err++; $display("FAIL hit_data got %h want %h", rd, gold_rd(32'h40)); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; int lat, ntx; bit done, h;
    cpu_access(32'h200, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h80);
    n_vec++; if (ntx !== 1 || lat !== rd_delay + 1 || h) begin n_err++; $display("FAIL conflict_a got tx=%0d lat=%0d want tx=1 lat=%0d", ntx, lat, rd_delay + 1); end
    n_vec++; if (rd !== gold_rd(32'h80)) begin n_err++; $display("FAIL conflict_a_data got %h want %h", rd, gold_rd(32'h80)); end
    cpu_access(32'h100, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h40);
    n_vec++; if (ntx !== 1 || lat !== rd_delay + 1 || h) begin n_err++; $display("FAIL conflict_evict got tx=%0d lat=%0d want tx=1 lat=%0d", ntx, lat, rd_delay + 1); end
    n_vec++; if (miss_count !== exp_cnt(miss_exp)) begin n_err++; $display("FAIL conflict_misses got %0d want %0d", miss_count, exp_cnt(miss_exp)); end
    n_vec++; if (hit_count !== exp_cnt(hits_exp)) begin n_err++; $display("FAIL conflict_hits got %0d want %0d", hit_count, exp_cnt(hits_exp)); end
  endtask

  task automatic test_write_merge();
    logic [31:0] rd; int lat, ntx; bit done, h;
    mem_img[32'h10] = 32'h1122_3344;
    gold[32'h10]    = 32'h1122_3344;
    cpu_access(32'h40, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h10);
    n_vec++; if (rd !== 32'h1122_3344 || h) begin n_err++; $display("FAIL wm_prefill got %h want 11223344", rd); end
    cpu_access(32'h40, 32'h0000_AA00, 4'b0010, -1, -1, rd, lat, ntx, done);
    mdl_write(32'h10, 32'h0000_AA00, 4'b0010);
    n_vec++; if (ntx !== 1 || lat !== wr_delay + 1) begin n_err++; $display("FAIL wm_write got tx=%0d lat=%0d want tx=1 lat=%0d", ntx, lat, wr_delay + 1); end
    n_vec++; if (last_m_wstrb !== 4'b0010 || last_m_wdata !== 32'h0000_AA00 || last_m_addr !== 32'h40) begin n_err++; $display("FAIL wm_fwd got %h/%h/%h want 2/0000aa00/40", last_m_wstrb, last_m_wdata, last_m_addr); end
    cpu_access(32'h40, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h10);
    n_vec++; if (rd !== 32'h1122_AA44) begin n_err++; $display("FAIL wm_read got %h want 1122aa44", rd); end
    n_vec++; if (ntx !== 0 || lat !== 1 || !h) begin n_err++; $display("FAIL wm_hit got tx=%0d lat=%0d want tx=0 lat=1", ntx, lat); end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd; int lat, ntx; bit done, h;
    cpu_access(32'h80, 32'hDEAD_BEEF, 4'hF, -1, -1, rd, lat, ntx, done);
    mdl_write(32'h20, 32'hDEAD_BEEF, 4'hF);
    n_vec++; if (ntx !== 1 || last_m_wdata !== 32'hDEAD_BEEF || last_m_addr !== 32'h80) begin n_err++; $display("FAIL wmiss_fwd got tx=%0d d=%h a=%h", ntx, last_m_wdata, last_m_addr); end
    cpu_access(32'h80, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h20);
    n_vec++; if (ntx !== 1 || h) begin n_err++; $display("FAIL wmiss_noalloc got tx=%0d want 1", ntx); end
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wmiss_data got %h want deadbeef", rd); end
  endtask

  task automatic test_flush_fill();
    logic [31:0] rd; int lat, ntx; bit done, h;
    cpu_access(32'h304, 32'h0, 4'h0, 5, -1, rd, lat, ntx, done);
    h = mdl_read(32'hC1);
    mdl_flush();
    n_vec++; if (done !== 1'b1 || ntx !== 1) begin n_err++; $display("FAIL flfill_done got done=%b tx=%0d", done, ntx); end
    n_vec++; if (rd !== gold_rd(32'hC1)) begin n_err++; $display("FAIL flfill_data got %h want %h", rd, gold_rd(32'hC1)); end
    cpu_access(32'h304, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'hC1);
    n_vec++; if (ntx !== 1 || lat !== rd_delay + 2 || h) begin n_err++; $display("FAIL flfill_reread got tx=%0d lat=%0d want tx=1 lat=%0d", ntx, lat, rd_delay + 2); end
    cpu_access(32'h304, 32'h0, 4'h0, 0, -1, rd, lat, ntx, done);
    mdl_flush();
    h = mdl_read(32'hC1);
    n_vec++; if (ntx !== 1 || lat !== rd_delay + 2 || h) begin n_err++; $display("FAIL flidle got tx=%0d lat=%0d want tx=1 lat=%0d", ntx, lat, rd_delay + 2); end
  endtask

  task automatic test_reset_fill();
    logic [31:0] rd; int lat, ntx; bit done, h;
    cpu_access(32'h100, 32'h0, 4'h0, -1, 5, rd, lat, ntx, done);
    #1;
    n_vec++; if (mbus.valid !== 1'b0) begin n_err++; $display("FAIL rstfill_m_valid got %b want 0", mbus.valid); end
    n_vec++; if (cbus.ready !== 1'b0) begin n_err++; $display("FAIL rstfill_mem_ready got %b want 0", cbus.ready); end
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
    cpu_access(32'h100, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
    h = mdl_read(32'h40);
    n_vec++; if (ntx !== 1 || lat !== rd_delay + 1 || h) begin n_err++; $display("FAIL rstfill_miss got tx=%0d lat=%0d want tx=1 lat=%0d", ntx, lat, rd_delay + 1); end
    n_vec++; if (miss_count !== exp_cnt(miss_exp) || hit_count !== exp_cnt(hits_exp)) begin n_err++; $display("FAIL rstfill_cnt got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_cnt(hits_exp), exp_cnt(miss_exp)); end
  endtask

  task automatic test_bypass();
    logic [31:0] rd; int lat, ntx; bit done, h;
    for (int i = 0; i < 2; i++) begin
      cpu_access(32'h0002_0000, 32'h0, 4'h0, -1, -1, rd, lat, ntx, done);
      h = mdl_read(32'h8000);
      n_vec++; if (ntx !== 1 || last_m_addr !== 32'h0002_0000 || h) begin n_err++; $display("FAIL bypass_fwd%0d got tx=%0d a=%h", i, ntx, last_m_addr); end
      n_vec++; if (rd !== gold_rd(32'h8000)) begin n_err++; $display("FAIL bypass_data%0d got %h want %h", i, rd, gold_rd(32'h8000)); end
    end
    n_vec++; if (miss_count !== exp_cnt(miss_exp) || hit_count !== exp_cnt(hits_exp)) begin n_err++; $display("FAIL bypass_cnt got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_cnt(hits_exp), exp_cnt(miss_exp)); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, a; logic [3:0] s; int lat, ntx, elat, etx; bit done, h;
    int unsigned w;
    for (int n = 0; n < 200; n++) begin
      rd_delay = $urandom_range(1, 5);
      wr_delay = $urandom_range(1, 5);
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        mdl_flush();
      end
      if ($urandom_range(0, 9) == 0) w = 32768 + $urandom_range(0, 3);
      else w = $urandom_range(0, 2) * 64 + $urandom_range(0, 3);
      a = (w << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cpu_access(a, d, s, -1, -1, rd, lat, ntx, done);
      if (s != 4'h0) begin
        mdl_write(w, d, s);
        elat = wr_delay + 1; etx = 1;
        n_vec++; if (last_m_wdata !== d || last_m_wstrb !== s) begin n_err++; $display("FAIL rnd_wfwd op%0d got %h/%h want %h/%h", n, last_m_wdata, last_m_wstrb, d, s); end
      end else begin
        h = mdl_read(w);
        elat = h ? 1 : rd_delay + 1; etx = h ? 0 : 1;
        n_vec++; if (rd !== gold_rd(w)) begin n_err++; $display("FAIL rnd_data op%0d addr %h got %h want %h", n, a, rd, gold_rd(w)); end
      end
      n_vec++; if (ntx !== etx || lat !== elat) begin n_err++; $display("FAIL rnd_timing op%0d addr %h got tx=%0d lat=%0d want tx=%0d lat=%0d", n, a, ntx, lat, etx, elat); end
      if (etx == 1) begin
        n_vec++; if (last_m_addr !== (w << 2)) begin n_err++; $display("FAIL rnd_m_addr op%0d got %h want %h", n, last_m_addr, w << 2); end
      end
    end
    rd_delay = 11;
    wr_delay = 16;
    n_vec++; if (hit_count !== exp_cnt(hits_exp) || miss_count !== exp_cnt(miss_exp)) begin n_err++; $display("FAIL rnd_cnt got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_cnt(hits_exp), exp_cnt(miss_exp)); end
    n_vec++; if (hold_err !== 1'b0) begin n_err++; $display("FAIL m_hold got %b want 0", hold_err); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    cbus.valid = 1'b0;
    cbus.addr  = 32'h0;
    cbus.wdata = 32'h0;
    cbus.wstrb = 4'h0;
    mdl_reset();
    test_reset();
    test_cold_read();
    test_conflict();
    test_write_merge();
    test_write_miss();
    test_flush_fill();
    test_reset_fill();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
